// File: rtl/gray_rx_decoder.sv
// gray_rx_decoder: synchronises a Gray word, decodes it to binary and flags up/down/illegal steps; define GRAYRX_ERRCNT_EN to build the saturating err_count
module gray_rx_decoder #(
  parameter int N = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] gray_in,
  output logic [N-1:0] bin_out,
  output logic         step_up,
  output logic         step_down,
  output logic         step_err,
  output logic [7:0]   err_count
);
  logic [SYNC_STAGES-1:0][N-1:0] sync_q;
  logic [N-1:0] g_s, g_prev_q, bin_new, bin_old, inc, dec, bin_out_q;
  logic chg, up_d, dn_d, err_d, up_q, dn_q, err_q;
  function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  assign g_s = sync_q[SYNC_STAGES-1];
  // decode both words and classify the change against the previous synchronised value
  always_comb begin
    bin_new = g2b(g_s);
    bin_old = g2b(g_prev_q);
    inc = bin_old + 1'b1;
    dec = bin_old - 1'b1;
    chg = g_s != g_prev_q;
    up_d = chg && bin_new == inc;
    dn_d = chg && !up_d && bin_new == dec;
    err_d = chg && !up_d && !dn_d;
  end
  // synchroniser chain, previous-word register, binary output and step pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      g_prev_q <= '0;
      bin_out_q <= '0;
      up_q <= 1'b0;
      dn_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gray_in};
      g_prev_q <= g_s;
      bin_out_q <= chg ? bin_new : bin_out_q;
      up_q <= up_d;
      dn_q <= dn_d;
      err_q <= err_d;
    end
  end
  assign bin_out = bin_out_q;
  assign step_up = up_q;
  assign step_down = dn_q;
  assign step_err = err_q;
`ifdef GRAYRX_ERRCNT_EN
  logic [7:0] cnt_q;
  // illegal-jump counter, updated on the same edge as the step_err pulse and held at 255
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (err_d && cnt_q != 8'hff) cnt_q <= cnt_q + 8'd1;
  end
  assign err_count = cnt_q;
`else
  assign err_count = 8'h00;
`endif
endmodule

// File: doc/gray_rx_decoder.md
Name: gray_rx_decoder

Overview:
- Receiving end of the team's Gray-coded LED/counter interface.
- Samples an N-bit Gray word from an external source (another board's LED bus, or the on-chip gray_Nbits counter looped back) and synchronises it to clk.
- Converts the word to binary and classifies every change as a legal up-step, a legal down-step, or an illegal jump.
- Feeds bin_out to DigitLEDdriver and the step pulses to monitoring logic.

Parameters:
- N, 8, width of Gray input and binary output.
- SYNC_STAGES, 2, number of input synchroniser flops (legal range 2..4).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- gray_in  input  N  asynchronous Gray-coded word.
- bin_out  output  N  registered binary equivalent of the synchronised word.
- step_up  output  1  one-cycle pulse: legal increment, bin_new == bin_old+1 mod 2^N.
- step_down  output  1  one-cycle pulse: legal decrement, bin_new == bin_old-1 mod 2^N.
- step_err  output  1  one-cycle pulse: word changed but is not ±1 from the previous value.
- err_count  output  8  saturating illegal-jump counter (see Optional Feature).

Behaviour:
- Reset:
  - Synchronous and active-high: takes effect on the first rising clk edge where rst=1.
  - Clears all sync stages, g_prev, bin_out, step_up, step_down, step_err and err_count to 0.
  - Asserting rst mid-operation aborts any in-flight sample.
  - After release, the first comparison is made against g_prev=0.
- Synchroniser: gray_in passes through a chain of SYNC_STAGES flops; the last stage is g_s.
- Conversion:
  - b[N-1] = g[N-1]; b[i] = b[i+1] ^ g[i].
  - Purely combinational on g_s and g_prev, giving bin_new and bin_old.
- Per-cycle classification, registered:
  - g_s == g_prev: no event; all pulses 0; bin_out holds.
  - bin_new == bin_old+1 mod 2^N: step_up=1.
  - bin_new == bin_old-1 mod 2^N: step_down=1.
  - Any other change: step_err=1.
  - On any change, bin_out <= bin_new and g_prev <= g_s in the same edge.
  - bin_out tracks the input even on error.
- Pulses:
  - Exactly one cycle wide.
  - At most one of step_up, step_down, step_err is high in any cycle.
  - Each pulse is aligned with the bin_out update.
- Latency: a change on gray_in reaches bin_out and the step pulse SYNC_STAGES+1 rising edges later.
- Wrap-around (N=8):
  - Gray 0x80 (bin 255) -> 0x00 (bin 0) is step_up.
  - 0x00 -> 0x80 is step_down.
  - No error at either boundary.
- Held input: a constant input produces no pulses, regardless of duration.
- Back-to-back changes: a change on every clk cycle yields a pulse on every cycle, each classified independently against the immediately previous synchronised value.
- No handshake: the block is a pure observer and never back-pressures the source.

Optional Feature:
- Macro: GRAYRX_ERRCNT_EN.
- Defined:
  - err_count increments by 1 in the cycle step_err is asserted.
  - Saturates at 255, with no wrap.
  - Cleared only by rst.
- Undefined:
  - Counter logic is not synthesised.
  - err_count is tied to 8'h00.
  - Port list is unchanged.

Test Plan:
1. rst=1 for 3 cycles with gray_in=0x5A -> bin_out=0x00, all pulses 0, err_count=0 throughout reset. Release rst -> exactly 3 cycles later step_err=1 and bin_out=0x6C.
2. From reset, drive gray_in 0x00,0x01,0x03,0x02,0x06, each held 4 cycles -> bin_out 0,1,2,3,4. step_up pulses once per change, each 3 cycles after the change; step_down and step_err stay 0.
3. Wrap-around:
   - Hold 0x80 (bin 255), then 0x00 -> single step_up, bin_out=0x00.
   - Then back to 0x80 -> single step_down, bin_out=0xFF.
4. Illegal jump: from 0x00 apply 0x03 -> step_err one cycle, bin_out=0x02. err_count=1 with GRAYRX_ERRCNT_EN defined, 0 without.
5. Saturation (macro defined): toggle gray_in between 0x00 and 0x03 for 300 changes -> err_count stops at 255 and stays 255; rst then clears it to 0.
6. Reset mid-stream: while stepping up at bin 0x10, assert rst for 1 cycle -> bin_out=0 on the next edge, in-flight pulse suppressed.
   - Next input 0x18 (bin 0x10) compared against 0 -> step_err.
